// File: rtl/ehgu_sfifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ehgu_fifo_pkg                                                              |
// | Shared sizing helpers and types for the ehgu synchronous FIFO.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ehgu_fifo_pkg;

   // Occupancy needs one more bit than the pointers so that "full" is representable.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int unsigned c_DEF_DEPTH = 32;

   typedef logic [cnt_w(c_DEF_DEPTH)-1:0] cnt_t;

endpackage : ehgu_fifo_pkg
`default_nettype wire

// File: rtl/ehgu_sfifo_sdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ehgu_sdp_ram                                                               |
// | Simple dual-port storage array: one synchronous write, one synchronous     |
// | read. Read-during-write to the same address returns the old contents.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ehgu_sdp_ram #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule : ehgu_sdp_ram
`default_nettype wire

// File: rtl/ehgu_sfifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ehgu_sfifo                                                                 |
// | Single-clock FWFT FIFO with valid/ready on both sides, registered head     |
// | word, occupancy/threshold flags, synchronous flush and peak watermark.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ehgu_sfifo
   import ehgu_fifo_pkg::*;
#(
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned AF_LEVEL = DEPTH - 4,
   parameter int unsigned AE_LEVEL = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   input  logic                    din_valid,
   output logic                    din_ready,
   input  logic [WIDTH-1:0]        din,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic [WIDTH-1:0]        dout,
   output logic [cnt_w(DEPTH)-1:0] count,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [cnt_w(DEPTH)-1:0] max_count
);

   localparam int unsigned c_CW = cnt_w(DEPTH);
   localparam int unsigned c_AW = $clog2(DEPTH);

   localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
   localparam logic [c_CW-1:0] c_AF   = c_CW'(AF_LEVEL);
   localparam logic [c_CW-1:0] c_AE   = c_CW'(AE_LEVEL);

   logic [c_AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [c_AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [c_CW-1:0]  count_q, count_d;
   logic [c_CW-1:0]  max_q, max_d;
   logic             dout_valid_q, dout_valid_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             din_ready_q;
   logic             af_q, ae_q;
   logic             byp_sel_q;
   logic [WIDTH-1:0] byp_q;
   logic [WIDTH-1:0] ram_rdata;

   logic             w_wr;
   logic             w_rd;
   logic             w_ram_we;
   logic             w_load;
   logic [c_CW-1:0]  w_ram_cnt;
   logic [WIDTH-1:0] w_head;

   assign w_wr      = din_valid & din_ready_q;
   assign w_rd      = dout_valid_q & dout_ready;
   assign w_ram_we  = w_wr & ~flush;
   assign w_ram_cnt = count_q - c_CW'(dout_valid_q);
   assign w_load    = (w_ram_cnt != '0) & (~dout_valid_q | w_rd);

   // A word written on the same edge its address was read back is stale in the
   // array's read register, so the head candidate comes from the bypass copy.
   assign w_head = byp_sel_q ? byp_q : ram_rdata;

   always_comb begin
      count_d      = count_q + c_CW'(w_wr) - c_CW'(w_rd);
      wr_ptr_d     = wr_ptr_q + c_AW'(w_wr);
      rd_ptr_d     = rd_ptr_q + c_AW'(w_load);
      dout_valid_d = dout_valid_q;
      dout_d       = dout_q;
      if (w_load) begin
         dout_valid_d = 1'b1;
         dout_d       = w_head;
      end else if (w_rd) begin
         dout_valid_d = 1'b0;
      end
      max_d = (count_d > max_q) ? count_d : max_q;
      if (flush) begin
         count_d      = '0;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         dout_valid_d = 1'b0;
         dout_d       = dout_q;
         max_d        = '0;
      end
   end

   ehgu_sdp_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (w_ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (din),
      .raddr_i (rd_ptr_d),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         max_q        <= '0;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
         din_ready_q  <= 1'b0;
         af_q         <= 1'b0;
         ae_q         <= 1'b1;
         byp_sel_q    <= 1'b0;
         byp_q        <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         max_q        <= max_d;
         dout_valid_q <= dout_valid_d;
         dout_q       <= dout_d;
         // Flags follow next-state occupancy so they never lag count by a cycle.
         din_ready_q  <= (count_d < c_FULL);
         af_q         <= (count_d >= c_AF);
         ae_q         <= (count_d <= c_AE);
         byp_sel_q    <= w_ram_we & (wr_ptr_q == rd_ptr_d);
         if (w_ram_we) begin
            byp_q <= din;
         end
      end
   end

   assign din_ready    = din_ready_q;
   assign dout_valid   = dout_valid_q;
   assign dout         = dout_q;
   assign count        = count_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign max_count    = max_q;

endmodule : ehgu_sfifo
`default_nettype wire

// File: tb/tb_ehgu_sfifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ehgu_sfifo                                                              |
// | Scoreboard bench for ehgu_sfifo against a queue-based reference model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ehgu_sfifo;
   import ehgu_fifo_pkg::*;

   localparam int unsigned c_DEPTH = 32;
   localparam int unsigned c_WIDTH = 8;
   localparam int unsigned c_AF    = c_DEPTH - 4;
   localparam int unsigned c_AE    = 4;

   logic               clk;
   logic               rstn;
   logic               flush;
   logic               din_valid;
   logic               din_ready;
   logic [c_WIDTH-1:0] din;
   logic               dout_valid;
   logic               dout_ready;
   logic [c_WIDTH-1:0] dout;
   cnt_t               count;
   logic               almost_full;
   logic               almost_empty;
   cnt_t               max_count;

   ehgu_sfifo #(
      .DEPTH    (c_DEPTH),
      .WIDTH    (c_WIDTH),
      .AF_LEVEL (c_AF),
      .AE_LEVEL (c_AE)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .flush        (flush),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .din          (din),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .dout         (dout),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .max_count    (max_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [c_WIDTH-1:0] d;
      int unsigned        e;
   } ent_t;

   ent_t        sbq[$];
   int unsigned m_max = 0;
   int unsigned ecnt  = 0;
   logic        armed;
   logic        wr_fire = 1'b0;
   int          total = 0;
   int          bad   = 0;
   logic [c_WIDTH-1:0] next_val;
   int          n_acc = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) ecnt <= ecnt + 1;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) armed <= 1'b0;
      else       armed <= 1'b1;
   end

   // Monitor: compare DUT state to the model, then apply the fires of the next edge.
   always @(negedge clk) begin : mon
      int unsigned sz;
      logic        exp_dv;
      sz     = sbq.size();
      exp_dv = (sz != 0) && (sbq[0].e < ecnt);
      check("count",        32'(count),        sz);
      check("din_ready",    32'(din_ready),    32'(armed && (sz < c_DEPTH)));
      check("dout_valid",   32'(dout_valid),   32'(exp_dv));
      check("almost_full",  32'(almost_full),  32'(sz >= c_AF));
      check("almost_empty", 32'(almost_empty), 32'(sz <= c_AE));
      check("max_count",    32'(max_count),    m_max);
      if (!rstn) check("reset_dout", 32'(dout), 0);
      if (exp_dv && dout_valid) check("head", 32'(dout), 32'(sbq[0].d));

      wr_fire = 1'b0;
      if (!rstn || flush) begin
         sbq.delete();
         m_max = 0;
      end else begin
         if (dout_valid && dout_ready) begin
            if (sbq.size() == 0) begin
               check("unexpected_read", 32'(dout_valid), 0);
            end else begin
               check("read_data", 32'(dout), 32'(sbq[0].d));
               void'(sbq.pop_front());
            end
         end
         if (din_valid && din_ready) begin
            sbq.push_back('{d: din, e: ecnt + 1});
            wr_fire = 1'b1;
         end
         if (sbq.size() > m_max) m_max = sbq.size();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (wr_fire) begin
         next_val = next_val + 8'd3;
         n_acc++;
      end
      din = next_val;
   endtask

   task automatic fill_to(input int n);
      din_valid  = 1'b1;
      dout_ready = 1'b0;
      for (int i = 0; i < 80 && int'(count) != n; i++) step();
      din_valid = 1'b0;
      check("fill_to", 32'(count), n);
   endtask

   task automatic drain();
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      for (int i = 0; i < 100 && count != '0; i++) step();
      dout_ready = 1'b0;
      check("drain", 32'(count), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn = 1'b0; flush = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
      next_val = 8'h00; din = 8'h00;
      repeat (5) @(posedge clk);
      #1;
      check("rst_din_ready", 32'(din_ready), 0);
      check("rst_ae",        32'(almost_empty), 1);
      rstn = 1'b1;
      step();
      check("ready_after_release", 32'(din_ready), 1);

      // Fill with +3 sequence, then read-at-full with a pending write.
      next_val = 8'h00; din = next_val;
      fill_to(32);
      check("full_ready", 32'(din_ready), 0);
      check("full_af",    32'(almost_full), 1);
      din_valid = 1'b1; dout_ready = 1'b1;
      step();
      din_valid = 1'b0; dout_ready = 1'b0;
      check("full_rd_count", 32'(count), 31);
      check("full_rd_ready", 32'(din_ready), 1);
      drain();
      check("peak", 32'(max_count), 32);

      // Empty-FIFO latency.
      next_val = 8'hA5; din = next_val;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      check("lat_count", 32'(count), 1);
      check("lat_early", 32'(dout_valid), 0);
      step();
      check("lat_valid", 32'(dout_valid), 1);
      check("lat_data",  32'(dout), 32'h A5);

      // Simultaneous read and write at count = 1.
      next_val = 8'h3C; din = next_val;
      din_valid = 1'b1; dout_ready = 1'b1;
      step();
      din_valid = 1'b0; dout_ready = 1'b0;
      check("c1_count", 32'(count), 1);
      step();
      check("c1_valid", 32'(dout_valid), 1);
      check("c1_data",  32'(dout), 32'h3C);
      drain();

      // Random streaming.
      next_val = 8'h00; din = next_val; n_acc = 0;
      for (int cyc = 0; cyc < 20000 && n_acc < 1000; cyc++) begin
         din_valid  = 1'($urandom_range(0, 1));
         dout_ready = 1'($urandom_range(0, 1));
         step();
      end
      din_valid = 1'b0;
      check("stream_words", 32'(n_acc >= 1000), 1);
      drain();

      // Flush mid-stream.
      fill_to(10);
      flush = 1'b1; din_valid = 1'b1; dout_ready = 1'b1;
      step();
      flush = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
      check("fl_count", 32'(count), 0);
      check("fl_valid", 32'(dout_valid), 0);
      check("fl_max",   32'(max_count), 0);
      check("fl_ready", 32'(din_ready), 1);
      step();
      check("fl_nowrite", 32'(count), 0);

      // Asynchronous reset pulse mid-stream.
      fill_to(10);
      din_valid = 1'b1; dout_ready = 1'b1;
      @(posedge clk);
      #2;
      rstn = 1'b0;
      sbq.delete();
      m_max = 0;
      #1;
      check("ar_count", 32'(count), 0);
      check("ar_valid", 32'(dout_valid), 0);
      check("ar_max",   32'(max_count), 0);
      check("ar_ready", 32'(din_ready), 0);
      check("ar_dout",  32'(dout), 0);
      #1;
      rstn = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
      step();
      check("ar_post_count", 32'(count), 0);
      check("ar_post_ready", 32'(din_ready), 1);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ehgu_sfifo
`default_nettype wire
